// File: rtl/prog_rom.sv
// Writable instruction store: answers the processor fetch port and accepts a new
// program over a byte-wide valid/ready loader stream, feeding NOPs while loading.
module prog_rom #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] instruction,
    input  logic              load_valid,
    input  logic [7:0]        load_byte,
    output logic              load_ready,
    output logic              loading,
    output logic              load_done,
    output logic              load_err
);

    typedef enum logic [2:0] {
        IDLE,
        COUNT,
        HI,
        LO,
        CHECK,
        DONE
    } state_t;

    localparam logic [7:0] HEADER    = 8'hA5;
    localparam logic [7:0] MAX_COUNT = 8'(DEPTH);

    state_t              state;
    logic [DATA_W-1:0]   mem [DEPTH];
    logic [ADDR_W-1:0]   ptr;
    logic [7:0]          count;
    logic [7:0]          hi_byte;
    logic [7:0]          csum;
    logic                accept;
    logic [7:0]          ptr_next;

    assign accept   = load_valid && load_ready;
    assign ptr_next = {{(8-ADDR_W){1'b0}}, ptr} + 8'd1;

    // Loader FSM, program storage and fetch register share one reset domain so a
    // reset mid-load wipes the partial frame and the memory together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            ptr         <= '0;
            count       <= '0;
            hi_byte     <= '0;
            csum        <= '0;
            load_ready  <= 1'b1;
            loading     <= 1'b0;
            load_done   <= 1'b0;
            load_err    <= 1'b0;
            instruction <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            instruction <= loading ? '0 : mem[address];
            load_done   <= 1'b0;

            case (state)
                IDLE: begin
                    if (accept && load_byte == HEADER) begin
                        state    <= COUNT;
                        load_err <= 1'b0;
                        loading  <= 1'b1;
                    end
                end
                COUNT: begin
                    if (accept) begin
                        count <= load_byte;
                        if (load_byte != 8'd0 && load_byte <= MAX_COUNT) begin
                            ptr   <= '0;
                            csum  <= '0;
                            state <= HI;
                        end else begin
                            load_err <= 1'b1;
                            loading  <= 1'b0;
                            state    <= IDLE;
                        end
                    end
                end
                HI: begin
                    if (accept) begin
                        hi_byte <= load_byte;
                        csum    <= csum ^ load_byte;
                        state   <= LO;
                    end
                end
                LO: begin
                    if (accept) begin
                        mem[ptr] <= {hi_byte, load_byte};
                        csum     <= csum ^ load_byte;
                        ptr      <= ptr + 1'b1;
                        // ptr wraps to 0 on a full-depth frame; ptr_next is wide enough to match N.
                        state    <= (ptr_next == count) ? CHECK : HI;
                    end
                end
                CHECK: begin
                    if (accept) begin
                        loading <= 1'b0;
                        if (load_byte == csum) begin
                            load_done  <= 1'b1;
                            load_ready <= 1'b0;
                            state      <= DONE;
                        end else begin
                            load_err <= 1'b1;
                            state    <= IDLE;
                        end
                    end
                end
                DONE: begin
                    load_ready <= 1'b1;
                    state      <= IDLE;
                end
                default: begin
                    load_ready <= 1'b1;
                    loading    <= 1'b0;
                    state      <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_prog_rom.sv
// Directed bench for prog_rom: reset fetch sweep, good/bad frames, count range
// errors, stream stalls and garbage, and reset in the middle of a frame.
module tb_prog_rom;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  address;
    logic [15:0] instruction;
    logic        load_valid;
    logic [7:0]  load_byte;
    logic        load_ready;
    logic        loading;
    logic        load_done;
    logic        load_err;

    int vec_count        = 0;
    int miscompare_count = 0;
    int done_count       = 0;
    int nop_violations   = 0;
    logic prev_loading   = 1'b0;

    logic [7:0]  good_frame [9] = '{8'hA5, 8'h03, 8'h10, 8'h05, 8'h21, 8'h40, 8'h80, 8'h00, 8'hF4};
    logic [15:0] good_words [3] = '{16'h1005, 16'h2140, 16'h8000};
    logic [7:0]  bad_frame  [9] = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h00};
    logic [15:0] bad_words  [3] = '{16'h1122, 16'h3344, 16'h5566};

    always #5 clk = ~clk;

    prog_rom dut (
        .clk        (clk),
        .rst        (rst),
        .address    (address),
        .instruction(instruction),
        .load_valid (load_valid),
        .load_byte  (load_byte),
        .load_ready (load_ready),
        .loading    (loading),
        .load_done  (load_done),
        .load_err   (load_err)
    );

    // The first loading cycle may still show the fetch captured on the header edge.
    always @(negedge clk) begin
        if (load_done) done_count++;
        if (loading && prev_loading && instruction != 16'h0000) nop_violations++;
        prev_loading = loading;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vec_count++;
        if (observed !== expected) begin
            miscompare_count++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] b);
        int waits = 0;
        @(negedge clk);
        load_valid = 1'b1;
        load_byte  = b;
        while (!load_ready && waits < 10) begin
            @(negedge clk);
            waits++;
        end
        if (!load_ready) checkOutput("ready_timeout", 32'(load_ready), 32'd1);
        @(posedge clk);
        #1;
        load_valid = 1'b0;
    endtask

    task automatic readWord(input int a, input logic [15:0] expected, input string tag);
        @(negedge clk);
        address = 4'(a);
        @(posedge clk);
        #1;
        checkOutput($sformatf("%s[%0d]", tag, a), 32'(instruction), 32'(expected));
    endtask

    task automatic sendGood();
        for (int i = 0; i < 9; i++) begin
            applyStimulus(good_frame[i]);
            if (i == 0) checkOutput("loading_rise", 32'(loading), 32'd1);
        end
    endtask

    initial begin
        rst        = 1'b1;
        address    = '0;
        load_valid = 1'b0;
        load_byte  = '0;
        #12 rst = 1'b0;

        @(negedge clk);
        checkOutput("rst_instruction", 32'(instruction), 32'd0);
        checkOutput("rst_ready", 32'(load_ready), 32'd1);
        checkOutput("rst_loading", 32'(loading), 32'd0);
        checkOutput("rst_done", 32'(load_done), 32'd0);
        checkOutput("rst_err", 32'(load_err), 32'd0);
        for (int i = 0; i < 16; i++) readWord(i, 16'h0000, "rst_sweep");

        // Good three-word frame.
        sendGood();
        checkOutput("good_done_pulse", 32'(load_done), 32'd1);
        checkOutput("good_ready_low", 32'(load_ready), 32'd0);
        checkOutput("good_loading_fall", 32'(loading), 32'd0);
        readWord(1, 16'h2140, "good_first_fetch");
        checkOutput("good_done_count", 32'(done_count), 32'd1);
        checkOutput("good_err", 32'(load_err), 32'd0);
        for (int i = 0; i < 16; i++) readWord(i, (i < 3) ? good_words[i] : 16'h0000, "good_mem");

        // Bad checksum keeps the partial writes.
        for (int i = 0; i < 9; i++) applyStimulus(bad_frame[i]);
        checkOutput("bad_err", 32'(load_err), 32'd1);
        checkOutput("bad_loading", 32'(loading), 32'd0);
        checkOutput("bad_ready", 32'(load_ready), 32'd1);
        for (int i = 0; i < 4; i++) readWord(i, (i < 3) ? bad_words[i] : 16'h0000, "bad_mem");
        checkOutput("bad_done_count", 32'(done_count), 32'd1);

        // Count out of range, both ends.
        applyStimulus(8'hA5);
        checkOutput("hdr_clears_err", 32'(load_err), 32'd0);
        applyStimulus(8'h00);
        checkOutput("count0_err", 32'(load_err), 32'd1);
        checkOutput("count0_loading", 32'(loading), 32'd0);
        applyStimulus(8'hA5);
        applyStimulus(8'h11);
        checkOutput("count17_err", 32'(load_err), 32'd1);
        checkOutput("count17_loading", 32'(loading), 32'd0);
        readWord(0, 16'h1122, "range_mem");
        readWord(1, 16'h3344, "range_mem");

        // Garbage, then a frame with a five-cycle stall between HI and LO.
        address = 4'd1;
        applyStimulus(8'h3C);
        checkOutput("garbage1_loading", 32'(loading), 32'd0);
        applyStimulus(8'hFF);
        checkOutput("garbage2_loading", 32'(loading), 32'd0);
        applyStimulus(8'hA5);
        applyStimulus(8'h02);
        applyStimulus(8'h12);
        repeat (5) @(negedge clk);
        checkOutput("stall_loading", 32'(loading), 32'd1);
        checkOutput("stall_nop", 32'(instruction), 32'd0);
        applyStimulus(8'h34);
        applyStimulus(8'hAB);
        applyStimulus(8'hCD);
        applyStimulus(8'h40);
        checkOutput("stream_done_pulse", 32'(load_done), 32'd1);
        readWord(0, 16'h1234, "stream_mem");
        readWord(1, 16'hABCD, "stream_mem");
        readWord(2, 16'h5566, "stream_mem");
        checkOutput("stream_err", 32'(load_err), 32'd0);
        checkOutput("stream_done_count", 32'(done_count), 32'd2);
        checkOutput("nop_during_load", 32'(nop_violations), 32'd0);

        // Reset after the fourth data byte.
        applyStimulus(8'hA5);
        applyStimulus(8'h00);
        checkOutput("preset_err", 32'(load_err), 32'd1);
        for (int i = 0; i < 6; i++) applyStimulus(good_frame[i]);
        @(negedge clk);
        rst = 1'b1;
        #2;
        checkOutput("async_rst_loading", 32'(loading), 32'd0);
        checkOutput("async_rst_instr", 32'(instruction), 32'd0);
        #1 rst = 1'b0;
        checkOutput("midrst_err", 32'(load_err), 32'd0);
        checkOutput("midrst_ready", 32'(load_ready), 32'd1);
        for (int i = 0; i < 16; i++) readWord(i, 16'h0000, "midrst_mem");

        sendGood();
        checkOutput("reload_done_pulse", 32'(load_done), 32'd1);
        for (int i = 0; i < 4; i++) readWord(i, (i < 3) ? good_words[i] : 16'h0000, "reload_mem");
        checkOutput("reload_done_count", 32'(done_count), 32'd3);

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompare_count);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "[TB] timeout");
    end

endmodule

// File: doc/prog_rom.md
# prog_rom

Writable 16-entry instruction store that answers the processor's instruction fetch port and accepts a new program over a byte-wide valid/ready loader stream. It sits between the processor (which drives `address` and consumes `instruction`) and a host-side byte source such as a UART receiver. While a load is in progress it feeds NOPs to the processor, so the processor never executes a half-written program.

## Interface
- `DEPTH`, 16: number of instruction words.
- `ADDR_W`, 4: fetch address width; `DEPTH` = 2^`ADDR_W`.
- `DATA_W`, 16: instruction width.
- `clk` in 1: the single clock. All state changes on its rising edge.
- `rst` in 1: reset. Asynchronous, active-high.
- `address` in `ADDR_W`: fetch address from the processor.
- `instruction` out `DATA_W`: fetched instruction word.
- `load_valid` in 1: `load_byte` is valid this cycle.
- `load_byte` in 8: loader stream byte.
- `load_ready` out 1: block accepts the byte this cycle.
- `loading` out 1: a load is in progress; fetches return NOP.
- `load_done` out 1: one-cycle pulse when a load completes with a good checksum.
- `load_err` out 1: sticky error flag.

## Operation
- **Storage.** `DEPTH` x `DATA_W` register array. Reset clears every word to 16'h0000, which is a NOP.
- **Handshake.** A byte transfers on any cycle where `load_valid` and `load_ready` are both high. `load_ready` is 1 in every state except DONE.
- **Frame format.** Header byte 8'hA5, then count byte N, then 2N data bytes, then checksum byte.
  - Data bytes come in word order from address 0. Each word is sent high byte first.
  - Checksum is the XOR of all 2N data bytes.
- **States and transitions.**
  - IDLE: a byte equal to 8'hA5 moves to COUNT and clears `load_err`. Any other byte is discarded and the state stays IDLE.
  - COUNT: latch N. If 1 <= N <= `DEPTH`, clear the word pointer and the running XOR, then go to HI. If N = 0 or N > `DEPTH`, set `load_err` and go to IDLE.
  - HI: latch the byte as the upper 8 bits, XOR it into the checksum, go to LO.
  - LO: write {hi, byte} to mem[pointer], XOR the byte in, increment the pointer.
    - If pointer+1 == N, go to CHECK.
    - Otherwise go to HI.
  - CHECK: if the byte equals the running XOR, go to DONE. Otherwise set `load_err` and go to IDLE.
  - DONE: hold for one cycle with `load_done`=1 and `load_ready`=0, then go to IDLE.
- **Unloaded words.** Words at addresses >= N keep their previous contents.
- **Failed checksum.** Words already written stay written. No rollback; the processor resumes on the partially updated program with `load_err`=1.
- **`loading`** is 1 when the state is COUNT, HI, LO or CHECK.
- **`load_err`** clears only on reset or on acceptance of the next 8'hA5 header in IDLE.
- **Fetch.**
  - If `loading`=1, the registered output loads 16'h0000.
  - Otherwise it loads mem[`address`].
- **Write/read collision.** A write and a read of the same address in one cycle is irrelevant, because output is forced to NOP during load. The first fetch after DONE sees the new data.

## Timing
- **Reset values.**
  - `instruction`=0, `load_done`=0, `load_err`=0, `loading`=0.
  - `load_ready`=1, state IDLE, pointer=0.
- **Fetch latency.** 1 cycle: the `address` sampled at edge k appears on `instruction` after edge k.
- **Loader throughput.** One byte per cycle except the DONE cycle.
- **Load duration.** A frame of N words takes 2N+3 accepted bytes plus 1 DONE cycle.
- **Output timing.**
  - `loading` rises on the edge that accepts the header.
  - `loading` falls on the edge that accepts the checksum byte.
  - `load_done` is high in the cycle after checksum acceptance.
- **Reset mid-load.** Immediate return to IDLE, memory cleared, all flags cleared. Any partial frame is lost.
- **`load_valid` low mid-frame.** The FSM holds state indefinitely. There is no timeout.

## Test plan
- **Reset and fetch.** Assert `rst`, release, sweep `address` 0..15 -> `instruction`=16'h0000 each cycle, one-cycle latency; `load_ready`=1.
- **Good 3-word load.** Send A5,03,10,05,21,40,80,00 then checksum (10^05^21^40^80^00)=F4 ->
  - mem[0..2] = 1005, 2140, 8000; mem[3..15] = 0.
  - `load_done` pulses once; `load_err`=0.
  - `address`=1 then returns 2140.
- **Bad checksum.** Same frame with checksum 00 -> `load_err`=1, no `load_done`, mem[0..2] updated, `loading` back to 0.
- **Count out of range.** Send A5,00, then later A5,11 -> `load_err`=1 after each COUNT byte, state IDLE, memory unchanged.
- **Stream flow.** Send garbage 3C,FF before a header, and toggle `load_valid` low for 5 cycles between HI and LO ->
  - Garbage is ignored and the load completes correctly.
  - `instruction`=0 throughout `loading`.
- **Reset mid-load.** Pulse `rst` after the 4th data byte -> memory all zero, state IDLE, `load_err`=0. A subsequent full frame loads normally.
